// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and sizes for the 1-to-4 stream demultiplexer
// Contents: state_t (IDLE, LOCKED), NUM_OUT (output count), SEL_W (select width).
package demux_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/demux1to4_if.sv
// rtl/demux1to4_if.sv - input stream plus four output streams of the demultiplexer
// Input stream:   a, a_valid, a_last, sel (driven by producer), a_ready (driven by demux).
// Output streams: y0..y3, y_valid, y_last (driven by demux), y_ready (driven by consumers).
// master: the producer/consumer side; slave: the demux side.
interface demux1to4_if #(
    parameter int WIDTH = 8
);
    import demux_pkg::*;

    logic [WIDTH-1:0]   a;
    logic               a_valid;
    logic               a_last;
    logic               a_ready;
    logic [SEL_W-1:0]   sel;

    logic [WIDTH-1:0]   y0;
    logic [WIDTH-1:0]   y1;
    logic [WIDTH-1:0]   y2;
    logic [WIDTH-1:0]   y3;
    logic [NUM_OUT-1:0] y_valid;
    logic [NUM_OUT-1:0] y_last;
    logic [NUM_OUT-1:0] y_ready;

    modport master (
        output a, a_valid, a_last, sel, y_ready,
        input  a_ready, y0, y1, y2, y3, y_valid, y_last
    );

    modport slave (
        input  a, a_valid, a_last, sel, y_ready,
        output a_ready, y0, y1, y2, y3, y_valid, y_last
    );

endinterface

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry holding register with valid/ready for one output
// Ports: clk, rst (async, active high); load/d/d_last write a beat; ready is the
// consumer ready; data/valid/last are the registered output; can_load tells the
// producer side a write this cycle is safe (empty, or draining this cycle).
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             d_last,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             last,
    output logic             can_load
);

    // Accepting while the consumer takes the old beat gives back-to-back beats.
    assign can_load = ~valid | ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            data  <= d;
            last  <= d_last;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1to4.sv
// rtl/demux1to4.sv - registered 1-to-4 packet stream demultiplexer
// Ports: clk, rst (async, active high); bus (demux1to4_if.slave) carries the input
// stream and the four output streams; busy is high while a packet is in progress;
// stat_sel/stat_cnt read the per-output packet counters.
// Build option: DEMUX1TO4_STATS_EN builds the saturating packet counters; without it
// stat_cnt reads 0 and stat_sel is ignored.
module demux1to4
    import demux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    demux1to4_if.slave           bus,
    output logic                 busy,
    input  logic [SEL_W-1:0]     stat_sel,
    output logic [CNT_WIDTH-1:0] stat_cnt
);

    state_t             state;
    state_t             state_next;
    logic [SEL_W-1:0]   cur_sel;
    logic [SEL_W-1:0]   cur_sel_next;
    logic [SEL_W-1:0]   target;
    logic               accept;
    logic [NUM_OUT-1:0] can_load;
    logic [NUM_OUT-1:0] load;
    logic [NUM_OUT-1:0] valid_v;
    logic [NUM_OUT-1:0] last_v;
    logic [WIDTH-1:0]   slot_data [NUM_OUT];

    // sel only matters on the first beat; later beats follow the latched destination.
    assign target      = (state == IDLE) ? bus.sel : cur_sel;
    assign bus.a_ready = can_load[target];
    assign accept      = bus.a_valid & bus.a_ready;

    always_comb begin
        load = '0;
        if (accept) begin
            load[target] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur_sel <= '0;
        end else begin
            state   <= state_next;
            cur_sel <= cur_sel_next;
        end
    end

    always_comb begin
        state_next   = state;
        cur_sel_next = cur_sel;
        case (state)
            IDLE: begin
                if (accept) begin
                    cur_sel_next = bus.sel;
                    if (!bus.a_last) begin
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (accept && bus.a_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == LOCKED);

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[i]),
            .d        (bus.a),
            .d_last   (bus.a_last),
            .ready    (bus.y_ready[i]),
            .data     (slot_data[i]),
            .valid    (valid_v[i]),
            .last     (last_v[i]),
            .can_load (can_load[i])
        );
    end

    assign bus.y0      = slot_data[0];
    assign bus.y1      = slot_data[1];
    assign bus.y2      = slot_data[2];
    assign bus.y3      = slot_data[3];
    assign bus.y_valid = valid_v;
    assign bus.y_last  = last_v;

`ifdef DEMUX1TO4_STATS_EN
    logic [CNT_WIDTH-1:0] cnt [NUM_OUT];

    // A packet is counted on its last beat; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                cnt[i] <= '0;
            end
        end else if (accept && bus.a_last && (cnt[target] != '1)) begin
            cnt[target] <= cnt[target] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign stat_cnt = cnt[stat_sel];
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_cnt        = '0;
`endif

endmodule
